fc_multipass_cu: RTL and testbench



---
 rtl/fc_multipass_cu.sv | 127 ++++++++++++
 tb/tb_fc_multipass_cu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_multipass_cu.sv
// Multi-pass FC layer control unit: sweeps the buffered IFM NUM_PASSES times per frame,
// emitting weight/IFM read addresses, MAC strobes and per-pass output-valid pulses.
module fc_multipass_cu #(
    parameter int IFM_DEPTH        = 160,
    parameter int NUM_PASSES       = 4,
    parameter int PIPE_DELAY       = 2,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_DEPTH),
    parameter int ADDRESS_SIZE_WM  = $clog2(IFM_DEPTH * NUM_PASSES),
    parameter int PASS_W           = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_from_previous,
    input  logic                        end_from_next,
    input  logic                        pause,
    output logic                        end_to_previous,
    output logic                        enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read,
    output logic                        wm_enable_read,
    output logic [ADDRESS_SIZE_WM-1:0]  wm_address_read,
    output logic                        bias_sel,
    output logic                        mac_enable,
    output logic                        fc_output_valid,
    output logic [PASS_W-1:0]           output_pass,
    output logic                        start_to_next
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                      state;
    logic [ADDRESS_SIZE_IFM-1:0] elem;
    logic [ADDRESS_SIZE_WM-1:0]  wm;
    logic [PASS_W-1:0]           pass;
    logic                        pending;

    logic read_en;
    logic last_elem;
    logic last_pass;

    // Delay line stage 0 holds what was issued in the previous cycle
    logic [PIPE_DELAY:0] rd_pipe;
    logic [PIPE_DELAY:0] first_pipe;
    logic [PIPE_DELAY:0] last_pipe;
    logic [PASS_W-1:0]   pass_pipe [PIPE_DELAY+1];

    always_comb begin
        read_en   = (state == RUN) && !pause;
        last_elem = (elem == ADDRESS_SIZE_IFM'(IFM_DEPTH - 1));
        last_pass = (pass == PASS_W'(NUM_PASSES - 1));
    end

    assign enable_read_current = read_en;
    assign wm_enable_read      = read_en;
    assign end_to_previous     = (state != RUN);
    assign ifm_address_read    = elem;
    assign wm_address_read     = wm;
    assign mac_enable          = rd_pipe[PIPE_DELAY-1];
    assign bias_sel            = first_pipe[PIPE_DELAY-1];
    assign fc_output_valid     = last_pipe[PIPE_DELAY];
    assign output_pass         = last_pipe[PIPE_DELAY] ? pass_pipe[PIPE_DELAY] : '0;
    assign start_to_next       = fc_output_valid && (output_pass == PASS_W'(NUM_PASSES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            elem       <= '0;
            wm         <= '0;
            pass       <= '0;
            pending    <= 1'b0;
            rd_pipe    <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            for (int i = 0; i <= PIPE_DELAY; i++) pass_pipe[i] <= '0;
        end else begin
            // Shifts unconditionally so a paused cycle travels down as a bubble
            rd_pipe      <= {rd_pipe[PIPE_DELAY-1:0], read_en};
            first_pipe   <= {first_pipe[PIPE_DELAY-1:0], read_en && (elem == '0)};
            last_pipe    <= {last_pipe[PIPE_DELAY-1:0], read_en && last_elem};
            pass_pipe[0] <= pass;
            for (int i = 1; i <= PIPE_DELAY; i++) pass_pipe[i] <= pass_pipe[i-1];

            case (state)
                IDLE: begin
                    if (start_from_previous) begin
                        state   <= RUN;
                        pending <= 1'b0;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        wm <= wm + 1'b1;
                        if (last_elem) begin
                            elem <= '0;
                            if (last_pass) begin
                                pass  <= '0;
                                wm    <= '0;
                                state <= DRAIN;
                            end else begin
                                pass <= pass + 1'b1;
                            end
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (start_from_previous) pending <= 1'b1;
                    if (start_to_next) state <= HOLD;
                end
                HOLD: begin
                    if (end_from_next) begin
                        if (pending || start_from_previous) begin
                            state   <= RUN;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start_from_previous) begin
                        pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_multipass_cu.sv
// Self-checking bench for fc_multipass_cu: a 4x3 multi-pass instance driven through
// nominal, paused, back-to-back, idle-return and reset frames, plus a 160x1 single-pass instance.
module tb_fc_multipass_cu;

    localparam int A_DEPTH  = 4;
    localparam int A_PASSES = 3;
    localparam int B_DEPTH  = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, endn, pause;
    logic a_etp, a_rd, a_wmen, a_bias, a_mac, a_valid, a_stn;
    logic [1:0] a_ifm, a_pass;
    logic [3:0] a_wm;

    logic b_start, b_endn, b_pause;
    logic b_etp, b_rd, b_wmen, b_bias, b_mac, b_valid, b_stn;
    logic [7:0] b_ifm, b_wm;
    logic [0:0] b_pass;

    fc_multipass_cu #(.IFM_DEPTH(A_DEPTH), .NUM_PASSES(A_PASSES), .PIPE_DELAY(2)) dut_a (
        .clk(clk), .reset(reset), .start_from_previous(start), .end_from_next(endn),
        .pause(pause), .end_to_previous(a_etp), .enable_read_current(a_rd),
        .ifm_address_read(a_ifm), .wm_enable_read(a_wmen), .wm_address_read(a_wm),
        .bias_sel(a_bias), .mac_enable(a_mac), .fc_output_valid(a_valid),
        .output_pass(a_pass), .start_to_next(a_stn));

    fc_multipass_cu #(.IFM_DEPTH(B_DEPTH), .NUM_PASSES(1), .PIPE_DELAY(2)) dut_b (
        .clk(clk), .reset(reset), .start_from_previous(b_start), .end_from_next(b_endn),
        .pause(b_pause), .end_to_previous(b_etp), .enable_read_current(b_rd),
        .ifm_address_read(b_ifm), .wm_enable_read(b_wmen), .wm_address_read(b_wm),
        .bias_sel(b_bias), .mac_enable(b_mac), .fc_output_valid(b_valid),
        .output_pass(b_pass), .start_to_next(b_stn));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    typedef struct { int c; int wm; int ifm; } rd_t;
    typedef struct { int c; int p; int stn; } vl_t;
    rd_t rdq[$];
    vl_t vq[$];
    int  macq[$];
    int  biasq[$];

    // Expected events of one A frame whose start is high in cycle 'base'; nothing at or after base+cutoff
    task automatic push_frame(input int base, input int ps, input int pl, input int cutoff);
        int t = base + 1;
        for (int k = 0; k < A_DEPTH * A_PASSES; k++) begin
            while (pl > 0 && t >= base + ps && t < base + ps + pl) t++;
            if (t < base + cutoff) rdq.push_back('{t, k, k % A_DEPTH});
            if (t + 2 < base + cutoff) begin
                macq.push_back(t + 2);
                if (k % A_DEPTH == 0) biasq.push_back(t + 2);
            end
            if (k % A_DEPTH == A_DEPTH - 1 && t + 3 < base + cutoff)
                vq.push_back('{t + 3, k / A_DEPTH, int'(k / A_DEPTH == A_PASSES - 1)});
            t++;
        end
    endtask

    rd_t r;
    vl_t v;
    int  m;
    int  b_cnt = 0;
    int  b_vcount = 0;
    int  bbase = 1 << 20;

    always @(negedge clk) begin
        if (a_rd) begin
            if (rdq.size() == 0) chk("read_unexpected", a_rd, 0);
            else begin
                r = rdq.pop_front();
                chk("read_cycle", cyc, r.c);
                chk("wm_addr", a_wm, r.wm);
                chk("ifm_addr", a_ifm, r.ifm);
                chk("wm_enable", a_wmen, 1);
                chk("etp_in_read", a_etp, 0);
            end
        end
        if (a_mac) begin
            if (macq.size() == 0) chk("mac_unexpected", a_mac, 0);
            else begin m = macq.pop_front(); chk("mac_cycle", cyc, m); end
        end
        if (a_bias) begin
            if (biasq.size() == 0) chk("bias_unexpected", a_bias, 0);
            else begin m = biasq.pop_front(); chk("bias_cycle", cyc, m); end
        end
        if (a_valid) begin
            if (vq.size() == 0) chk("valid_unexpected", a_valid, 0);
            else begin
                v = vq.pop_front();
                chk("valid_cycle", cyc, v.c);
                chk("output_pass", a_pass, v.p);
                chk("start_to_next", a_stn, v.stn);
            end
        end
        if (a_stn) chk("stn_alone", a_valid, 1);
        if (b_rd) begin
            chk("b_wm_addr", b_wm, b_cnt);
            chk("b_read_cycle", cyc, bbase + 1 + b_cnt);
            b_cnt++;
        end
        if (b_valid) begin
            b_vcount++;
            chk("b_valid_cycle", cyc, bbase + 163);
            chk("b_start_to_next", b_stn, 1);
            chk("b_output_pass", b_pass, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_etp"}, a_etp, 1);
        chk({tag, "_rd"}, a_rd, 0);
        chk({tag, "_wmen"}, a_wmen, 0);
        chk({tag, "_mac"}, a_mac, 0);
        chk({tag, "_bias"}, a_bias, 0);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_stn"}, a_stn, 0);
    endtask

    int b1, b3, b4;

    initial begin
        reset = 1'b0; start = 1'b0; endn = 1'b0; pause = 1'b0;
        b_start = 1'b0; b_endn = 1'b0; b_pause = 1'b0;
        tick(); tick();
        chk_quiet("reset");
        chk("reset_wm", a_wm, 0);
        chk("reset_ifm", a_ifm, 0);
        chk("reset_pass", a_pass, 0);
        reset = 1'b1;
        tick(); tick();

        // Frame 1 nominal, frame 2 queued from DRAIN with a two-cycle pause
        b1 = cyc;
        push_frame(b1, 0, 0, 1000);
        start = 1'b1; tick(); start = 1'b0;
        goto(b1 + 14);
        chk("etp_drain", a_etp, 1);
        push_frame(b1 + 18, 5, 2, 1000);
        start = 1'b1; tick(); start = 1'b0;
        goto(b1 + 16);
        chk("hold_rd", a_rd, 0);
        chk("etp_hold", a_etp, 1);
        goto(b1 + 18);
        endn = 1'b1; tick(); endn = 1'b0;
        goto(b1 + 23);
        pause = 1'b1;
        goto(b1 + 25);
        chk("etp_paused", a_etp, 0);
        pause = 1'b0;

        // HOLD with no pending start returns to IDLE
        goto(b1 + 37);
        endn = 1'b1; tick(); endn = 1'b0;
        repeat (5) tick();
        chk_quiet("idle");

        // Frame 3 killed by asynchronous reset in cycle 6
        b3 = cyc;
        push_frame(b3, 0, 0, 6);
        start = 1'b1; tick(); start = 1'b0;
        goto(b3 + 6);
        chk("pre_reset_rd", a_rd, 1);
        reset = 1'b0;
        #1;
        chk_quiet("async_reset");
        chk("async_reset_wm", a_wm, 0);
        chk("async_reset_ifm", a_ifm, 0);
        chk("async_reset_pass", a_pass, 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk_quiet("post_reset");

        // Frame 4 restarts cleanly from wm=0, pass=0
        b4 = cyc;
        push_frame(b4, 0, 0, 1000);
        start = 1'b1; tick(); start = 1'b0;
        goto(b4 + 20);
        chk("etp_hold4", a_etp, 1);
        endn = 1'b1; tick(); endn = 1'b0;
        repeat (3) tick();

        // Single-pass instance
        bbase = cyc;
        b_start = 1'b1; tick(); b_start = 1'b0;
        goto(bbase + 170);
        chk("b_read_count", b_cnt, B_DEPTH);
        chk("b_valid_count", b_vcount, 1);
        chk("b_etp_hold", b_etp, 1);
        b_endn = 1'b1; tick(); b_endn = 1'b0;
        tick();

        chk("rdq_left", rdq.size(), 0);
        chk("macq_left", macq.size(), 0);
        chk("biasq_left", biasq.size(), 0);
        chk("vq_left", vq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
